daddb_seq: RTL

Parametrised, registered successor to the blitter data-adder B-operand mux. Per lane, it selects either that lane's word of source data, or a broadcast word taken from the intensity or Z increment. Adds a ready/valid pipeline stage, a per-lane enable mask, and an auto-sequenced fraction-then-integer mode that emits the low and high increment words on consecutive beats. Sits between the blitter source-data/increment registers and the data adder B input.

---
 rtl/daddb_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/daddb_seq.sv
// daddb_seq: registered B-operand selector for the blitter data adder.
//
// Each of LANES output words is either the matching lane of source data or a
// broadcast word taken from the intensity or Z increment. A ready/valid
// output register, a per-lane enable mask and a lo-then-hi auto-sequenced
// broadcast mode sit on top of the basic mux.
//
// Optional feature, compiled in by defining the macro DADDB_NEG_EN:
//   two's-complement negation of the full 2*WIDTH broadcast increment
//   (controlled by in_neg) before it is split into lo/hi words. Without the
//   macro in_neg is accepted but ignored and no negation logic exists.
module daddb_seq #(
  parameter int LANES = 4,
  parameter int WIDTH = 16,
  parameter int CNTW  = 16
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_sel,
  input  logic                   in_seq,
  input  logic                   in_neg,
  input  logic [LANES-1:0]       lane_en,
  input  logic [LANES*WIDTH-1:0] srcd,
  input  logic [2*WIDTH-1:0]     iinc,
  input  logic [2*WIDTH-1:0]     zinc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] addb,
  output logic                   out_last,
  output logic [CNTW-1:0]        beat_cnt
);

  // Sequencer states: IDLE accepts requests, HI_PEND owes the hi word of a
  // sequenced pair and accepts nothing until that word has been loaded.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_HI_PEND = 1'b1;

  logic [0:0]             state;

  // Request context captured at accept time so that the hi beat of a
  // sequenced pair is immune to later changes on the input bus. Only the
  // already-selected (and possibly negated) hi word is needed.
  logic [WIDTH-1:0]       cap_hi;
  logic [LANES-1:0]       cap_en;

  logic                   accept;
  logic                   xfer;
  logic                   bcast;
  logic                   seq_req;
  logic [2*WIDTH-1:0]     inc_sel;
  logic [2*WIDTH-1:0]     inc_eff;
  logic [WIDTH-1:0]       bcast_word;
  logic [LANES*WIDTH-1:0] load_data;
  logic [LANES*WIDTH-1:0] hi_data;

  // Handshake: a new request may enter only when the sequencer is idle and
  // the output register is empty or being emptied this very cycle.
  assign in_ready = ~reset & (state == ST_IDLE) & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;
  assign bcast    = in_sel[2];
  assign seq_req  = in_sel[2] & in_seq;

`ifdef DADDB_NEG_EN
  // Select the increment and negate the full double-width value so that a
  // lo/hi pair carries correctly across the word boundary.
  always_comb begin
    inc_sel = in_sel[1] ? zinc : iinc;
    inc_eff = in_neg ? (~inc_sel + 1'b1) : inc_sel;
  end
`else
  // Select the increment; in_neg has no effect in this build.
  always_comb begin
    inc_sel = in_sel[1] ? zinc : iinc;
    inc_eff = inc_sel;
  end

  logic unused_neg;
  assign unused_neg = in_neg;
`endif

  // Build the word to load on accept: source lanes or the broadcast word,
  // with disabled lanes forced to zero. A sequenced request always starts
  // with the lo word regardless of in_sel[0].
  always_comb begin
    // NOTE: every variable gets a default before any conditional logic so
    // that no path leaves it unassigned, which would infer a latch.
    load_data  = '0;
    bcast_word = (in_sel[0] & ~seq_req) ? inc_eff[2*WIDTH-1:WIDTH]
                                        : inc_eff[WIDTH-1:0];
    for (int k = 0; k < LANES; k++) begin
      if (lane_en[k]) begin
        load_data[k*WIDTH +: WIDTH] = bcast ? bcast_word
                                            : srcd[k*WIDTH +: WIDTH];
      end
    end
  end

  // Build the hi beat of a sequenced pair from the captured context only.
  always_comb begin
    hi_data = '0;
    for (int k = 0; k < LANES; k++) begin
      if (cap_en[k]) begin
        hi_data[k*WIDTH +: WIDTH] = cap_hi;
      end
    end
  end

  // Output register, sequencer state and request capture.
  always_ff @(posedge sys_clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      addb      <= '0;
      cap_hi    <= '0;
      cap_en    <= '0;
    end else if (accept) begin
      addb      <= load_data;
      out_valid <= 1'b1;
      out_last  <= ~seq_req;
      state     <= seq_req ? ST_HI_PEND : ST_IDLE;
      cap_hi    <= inc_eff[2*WIDTH-1:WIDTH];
      cap_en    <= lane_en;
    end else if ((state == ST_HI_PEND) && xfer) begin
      addb      <= hi_data;
      out_valid <= 1'b1;
      out_last  <= 1'b1;
      state     <= ST_IDLE;
    end else if (xfer) begin
      out_valid <= 1'b0;
    end
  end

  // Count transferred output beats; wraps naturally at 2^CNTW.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      beat_cnt <= '0;
    end else if (xfer) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule
